lenet5_result_reader: RTL

//  Read-back engine, the outbound counterpart of the loader write port. After the accelerator finishes,
//  it reads output feature maps from the K_CHANNELS global SRAM banks and serialises them as a byte stream
//  to the host. Order: group, then pixel, then channel. Sits beside the loader on the global-mem port;
//  the top muxes the read port to this block only while accelerator_busy_o=0.

---
 rtl/lenet5_result_reader_pkg.sv | 22 ++
 rtl/lenet5_result_reader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/lenet5_result_reader_pkg.sv
// Shared definitions for the result reader: bank geometry and FSM encoding.
package lenet5_result_reader_pkg;

   localparam int K_CHANNELS = 6;
   localparam int DATA_W     = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
   } rdr_state_e;

   // A final-group channel count of 0, or one larger than the bank count, means a full group.
   function automatic logic [3:0] clamp_last_ch(input logic [3:0] last_ch);
      if (last_ch == 4'd0 || last_ch > 4'(K_CHANNELS))
         return 4'(K_CHANNELS);
      return last_ch;
   endfunction

endpackage

// File: rtl/lenet5_result_reader.sv
// Reads output feature maps from the channel SRAM banks and streams them out
// byte by byte, ordered group -> pixel -> channel.
//
// state   | meaning
// IDLE    | waiting for start_i, outputs quiet
// RD_REQ  | one-cycle read strobe for the current pixel address
// RD_WAIT | waiting RD_LAT cycles, capture bank data on the last one
// SEND    | stream the held channels of this pixel
// DONE    | one-cycle done pulse
module lenet5_result_reader
   import lenet5_result_reader_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_async_n_i,
   input  logic                         start_i,
   input  logic [ADDR_W-1:0]            cfg_base_addr_i,
   input  logic [15:0]                  cfg_pixels_i,
   input  logic [3:0]                   cfg_groups_i,
   input  logic [3:0]                   cfg_last_ch_i,
   output logic                         mem_rd_en_o,
   output logic [ADDR_W-1:0]            mem_rd_addr_o,
   input  logic [K_CHANNELS*DATA_W-1:0] mem_rd_data_i,
   output logic                         m_valid_o,
   output logic [DATA_W-1:0]            m_data_o,
   output logic                         m_last_o,
   input  logic                         m_ready_i,
   output logic                         busy_o,
   output logic                         done_o
);

   localparam int WAIT_W = $clog2(RD_LAT + 1);

   rdr_state_e                  state_q, state_d;
   logic [15:0]                 pixels_q;
   logic [3:0]                  groups_q;
   logic [3:0]                  last_ch_q;
   logic [ADDR_W-1:0]           grp_base_q;
   logic [3:0]                  ch_q;
   logic [15:0]                 p_q;
   logic [3:0]                  g_q;
   logic [WAIT_W-1:0]           wait_q;
   logic [K_CHANNELS*DATA_W-1:0] hold_q;

   logic       last_grp, last_pix, last_ch_beat, final_beat, hs;
   logic [3:0] n_ch;

   assign last_grp     = (g_q == groups_q - 4'd1);
   assign n_ch         = last_grp ? last_ch_q : 4'(K_CHANNELS);
   assign last_ch_beat = (ch_q == n_ch - 4'd1);
   assign last_pix     = (p_q == pixels_q - 16'd1);
   assign final_beat   = last_grp && last_pix && last_ch_beat;
   assign hs           = (state_q == SEND) && m_ready_i;

   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) state_q <= IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_i)
               state_d = (cfg_pixels_i == 16'd0 || cfg_groups_i == 4'd0) ? DONE : RD_REQ;
         end
         RD_REQ:  state_d = RD_WAIT;
         RD_WAIT: if (wait_q == '0) state_d = SEND;
         SEND:    if (hs && last_ch_beat) state_d = final_beat ? DONE : RD_REQ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Group base address advances by one stride per group so no multiplier is needed.
   always_ff @(posedge clk_i or negedge rst_async_n_i) begin
      if (!rst_async_n_i) begin
         pixels_q   <= '0;
         groups_q   <= '0;
         last_ch_q  <= '0;
         grp_base_q <= '0;
         ch_q       <= '0;
         p_q        <= '0;
         g_q        <= '0;
         wait_q     <= '0;
         hold_q     <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  pixels_q   <= cfg_pixels_i;
                  groups_q   <= cfg_groups_i;
                  last_ch_q  <= clamp_last_ch(cfg_last_ch_i);
                  grp_base_q <= cfg_base_addr_i;
                  ch_q       <= '0;
                  p_q        <= '0;
                  g_q        <= '0;
               end
            end
            RD_REQ: wait_q <= WAIT_W'(RD_LAT - 1);
            RD_WAIT: begin
               if (wait_q == '0) begin
                  hold_q <= mem_rd_data_i;
                  ch_q   <= '0;
               end else begin
                  wait_q <= wait_q - 1'b1;
               end
            end
            SEND: begin
               if (hs) begin
                  if (last_ch_beat) begin
                     ch_q <= '0;
                     if (last_pix) begin
                        p_q        <= '0;
                        g_q        <= g_q + 4'd1;
                        grp_base_q <= grp_base_q + ADDR_W'(pixels_q);
                     end else begin
                        p_q <= p_q + 16'd1;
                     end
                  end else begin
                     ch_q <= ch_q + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_rd_en_o   = 1'b0;
      mem_rd_addr_o = '0;
      m_valid_o     = 1'b0;
      m_data_o      = '0;
      m_last_o      = 1'b0;
      busy_o        = (state_q != IDLE);
      done_o        = (state_q == DONE);
      if (state_q == RD_REQ) begin
         mem_rd_en_o   = 1'b1;
         mem_rd_addr_o = grp_base_q + ADDR_W'(p_q);
      end
      if (state_q == SEND) begin
         m_valid_o = 1'b1;
         m_last_o  = final_beat;
         for (int k = 0; k < K_CHANNELS; k++)
            if (ch_q == 4'(k)) m_data_o = hold_q[k*DATA_W +: DATA_W];
      end
   end

endmodule
